// File: rtl/ef.sv
// Folded FIR equalizer: one signed MAC reused over TAP_N cycles per sample,
// saturating rescale to the output format once the sum is complete.
module ef #(
    parameter int unsigned TAP_N   = 17,
    parameter int unsigned DI_IL_W = 2,
    parameter int unsigned DI_FL_W = 5,
    parameter int unsigned DI_W    = DI_IL_W + DI_FL_W + 1,
    parameter int unsigned C_IL_W  = 2,
    parameter int unsigned C_FL_W  = 5,
    parameter int unsigned C_W     = C_IL_W + C_FL_W + 1,
    parameter int unsigned DO_IL_W = 2,
    parameter int unsigned DO_FL_W = 5,
    parameter int unsigned DO_W    = DO_IL_W + DO_FL_W + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    input  logic [DI_W-1:0]        data_i,
    input  logic [TAP_N*C_W-1:0]   coeff_i,
    output logic                   valid_o,
    output logic [DO_W-1:0]        data_o
);

    localparam int unsigned P_W   = DI_W + C_W;
    localparam int unsigned ACC_W = P_W + $clog2(TAP_N);
    localparam int unsigned S     = DI_FL_W + C_FL_W - DO_FL_W;
    localparam int unsigned IDX_W = $clog2(TAP_N + 1);
    localparam int unsigned TAP_W = (TAP_N > 1) ? $clog2(TAP_N) : 1;

    typedef enum logic [0:0] {IDLE, BUSY} state_e;

    state_e                   state_q;
    logic                     valid_q;
    logic [DO_W-1:0]          data_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DI_W-1:0]   x_q [TAP_N];

    logic signed [C_W-1:0]    c_arr [TAP_N];
    logic [TAP_W-1:0]         tap_sel;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [ACC_W-DO_W:0]      acc_top;
    logic [DO_W-1:0]          sat_d;

    for (genvar k = 0; k < int'(TAP_N); k++) begin : g_coeff
        assign c_arr[k] = coeff_i[C_W*k +: C_W];
    end

    // MAC datapath; tap select is clamped so the final (output) cycle never indexes past the line
    always_comb begin
        tap_sel = '0;
        if (idx_q < IDX_W'(TAP_N)) begin
            tap_sel = TAP_W'(idx_q);
        end
        prod    = c_arr[tap_sel] * x_q[tap_sel];
        acc_d   = acc_q + ACC_W'(prod);
        acc_shr = acc_q >>> S;
        acc_top = acc_shr[ACC_W-1:DO_W-1];
    end

    // In range when every bit above the output sign matches it; otherwise clip by sign
    always_comb begin
        sat_d = acc_shr[DO_W-1:0];
        if (!((&acc_top) || (~|acc_top))) begin
            sat_d = acc_shr[ACC_W-1] ? {1'b1, {(DO_W-1){1'b0}}} : {1'b0, {(DO_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            for (int k = 0; k < int'(TAP_N); k++) begin
                x_q[k] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        x_q[0] <= data_i;
                        for (int k = 1; k < int'(TAP_N); k++) begin
                            x_q[k] <= x_q[k-1];
                        end
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (idx_q == IDX_W'(TAP_N)) begin
                        data_q  <= sat_d;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_ef.sv
// Directed bench for ef: impulse response, latency, saturation, truncation,
// busy-drop and mid-computation reset.
module tb_ef;

    localparam int TAP_N = 17;

    logic                 clk;
    logic                 rst_n;
    logic                 valid_i;
    logic [7:0]           data_i;
    logic [TAP_N*8-1:0]   coeff_i;
    logic                 valid_o;
    logic [7:0]           data_o;

    int n_tests;
    int n_fail;
    int imp_c [TAP_N];

    ef dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .data_i  (data_i),
        .coeff_i (coeff_i),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_coeffs(input int c [TAP_N]);
        for (int k = 0; k < TAP_N; k++) begin
            coeff_i[8*k +: 8] = 8'(c[k]);
        end
    endtask

    task automatic set_all_coeffs(input int v);
        for (int k = 0; k < TAP_N; k++) begin
            coeff_i[8*k +: 8] = 8'(v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one sample, optionally inject a second valid_i before edge inj,
    // then check latency to valid_o and the result value.
    task automatic send(input int x, input int exp_y, input string tag, input int inj);
        int lat;
        lat = 0;
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 8'(x);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            if (i == inj) begin
                valid_i = 1'b1;
                data_i  = 8'd99;
            end
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            if (valid_o) lat = i;
        end
        check({tag, "_lat"}, lat, 18);
        check(tag, int'($signed(data_o)), exp_y);
    endtask

    initial begin
        int pulses;
        int held;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        imp_c   = '{32, -29, 0, 23, -21, 15, -10, 7, -5, 3, -2, 1, 1, -1, 0, 2, -3};
        set_coeffs(imp_c);

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(valid_o), 0);
        check("rst_data", int'($signed(data_o)), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse: x=32 (1.0) then zeros reproduces the taps, then 0
        send(32, imp_c[0], "imp0", 0);
        @(posedge clk);
        #1;
        check("pulse_clear", int'(valid_o), 0);
        check("hold_after_pulse", int'($signed(data_o)), imp_c[0]);
        for (int n = 1; n < TAP_N; n++) begin
            send(0, imp_c[n], $sformatf("imp%0d", n), 0);
        end
        send(0, 0, "imp_tail", 0);

        // Output holds, no spurious pulses while idle
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (valid_o) pulses++;
        end
        held = int'($signed(data_o));
        check("idle_pulses", pulses, 0);
        check("idle_hold", held, 0);

        // Positive saturation
        do_reset();
        set_all_coeffs(127);
        send(127, 127, "satp_first", 0);
        for (int n = 1; n < TAP_N; n++) send(127, 127, "satp", 0);

        // Negative saturation
        do_reset();
        send(-128, -128, "satn_first", 0);
        for (int n = 1; n < TAP_N; n++) send(-128, -128, "satn", 0);

        // Two taps, in-range: 16*10>>>5=5, (16*-7 - 8*10)>>>5 = -192>>>5 = -6
        do_reset();
        set_all_coeffs(0);
        coeff_i[7:0]  = 8'd16;
        coeff_i[15:8] = 8'(-8);
        send(10, 5, "two_a", 0);
        send(-7, -6, "two_b", 0);
        // Truncation toward -inf: coefficient 1.0 (32) would keep x; here c0=1 so -3>>>5=-1, 3>>>5=0
        do_reset();
        set_all_coeffs(0);
        coeff_i[7:0] = 8'd1;
        send(-3, -1, "trunc_neg", 0);
        send(3, 0, "trunc_pos", 0);

        // Busy drop: extra valid_i at E5 must not produce a result or enter the line
        do_reset();
        set_coeffs(imp_c);
        send(32, imp_c[0], "drop", 5);
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (valid_o) pulses++;
        end
        check("drop_pulses", pulses, 0);
        send(0, imp_c[1], "drop_next", 0);

        // Reset mid-computation (after E7, before E8)
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 8'd32;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(valid_o), 0);
        check("midrst_data", int'($signed(data_o)), 0);
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid_o) pulses++;
        end
        check("midrst_pulses", pulses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            send(n == 0 ? 32 : 0, imp_c[n], $sformatf("post_rst%0d", n), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
